axis_i2s_transmitter: RTL

AXIS_I2S_TRANSMITTER -- requirements
Module: axis_i2s_transmitter

---
 rtl/axis_i2s_transmitter_if.sv | 22 ++
 rtl/axis_i2s_transmitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2s_transmitter_if.sv
// AXI-Stream sample channel feeding the I2S transmitter.
// The source drives data/valid/last; the transmitter returns ready.
interface axis_i2s_transmitter_if;
  logic [31:0] s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic        s_axis_last;

  modport master (
    output s_axis_data,
    output s_axis_valid,
    output s_axis_last,
    input  s_axis_ready
  );

  modport slave (
    input  s_axis_data,
    input  s_axis_valid,
    input  s_axis_last,
    output s_axis_ready
  );
endinterface

// File: rtl/axis_i2s_transmitter.sv
// Stereo AXI-Stream to I2S serializer: a left/right packet is buffered, then
// moved into shadow registers at each 64-bit frame start and shifted out MSB first.
module axis_i2s_transmitter #(
  parameter int SCLK_HALF = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  axis_i2s_transmitter_if.slave        s_axis,
  output logic                         i2s_sclk,
  output logic                         i2s_lrck,
  output logic                         i2s_sdout,
  output logic                         underrun,
  output logic                         framing_err
);

  localparam int              CW      = $clog2(SCLK_HALF);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCLK_HALF - 1);

  typedef enum logic {
    WAIT_L = 1'b0,
    WAIT_R = 1'b1
  } in_state_t;

  in_state_t   state_q, state_d;

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          sclk_q, sclk_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic          lrck_q, lrck_d;
  logic          sdout_q, sdout_d;

  logic [23:0]   left_q, left_d;
  logic [23:0]   right_q, right_d;
  logic          buf_full_q, buf_full_d;
  logic [23:0]   shadow_l_q, shadow_l_d;
  logic [23:0]   shadow_r_q, shadow_r_d;

  logic          ready_q, ready_d;
  logic          underrun_q, underrun_d;
  logic          framing_err_q, framing_err_d;

  logic          xfer;
  logic          store_left;
  logic          store_right;
  logic          malformed;
  logic          half_tick;
  logic          fall_tick;
  logic          frame_start;
  logic [4:0]    slot_pos;
  logic [4:0]    sample_idx;
  logic [23:0]   slot_sample;
  logic          unused_hi;

  assign unused_hi   = ^s_axis.s_axis_data[31:24];

  assign xfer        = s_axis.s_axis_valid && ready_q;
  assign half_tick   = (clk_cnt_q == CNT_MAX);
  assign fall_tick   = half_tick && sclk_q;
  assign frame_start = fall_tick && (bit_cnt_q == 6'd63);

  // ---------------------------------------------------------------------------
  // Input packet FSM: state register / next state / decoded actions
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops update
    // from the same pre-edge values regardless of statement order.
    if (reset) state_q <= WAIT_L;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: each combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      WAIT_L: if (xfer && !s_axis.s_axis_last) state_d = WAIT_R;
      WAIT_R: if (xfer &&  s_axis.s_axis_last) state_d = WAIT_L;
      default: state_d = WAIT_L;
    endcase
  end

  always_comb begin
    store_left  = 1'b0;
    store_right = 1'b0;
    malformed   = 1'b0;
    unique case (state_q)
      WAIT_L: begin
        if (xfer) begin
          store_left = !s_axis.s_axis_last;
          malformed  =  s_axis.s_axis_last;
        end
      end
      WAIT_R: begin
        // A second left word replaces the first one rather than being dropped.
        if (xfer) begin
          store_right =  s_axis.s_axis_last;
          store_left  = !s_axis.s_axis_last;
          malformed   = !s_axis.s_axis_last;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet buffer and frame-start hand-off to the shadow registers
  // ---------------------------------------------------------------------------
  always_comb begin
    left_d        = left_q;
    right_d       = right_q;
    buf_full_d    = buf_full_q;
    shadow_l_d    = shadow_l_q;
    shadow_r_d    = shadow_r_q;
    underrun_d    = 1'b0;
    framing_err_d = malformed;

    if (frame_start) begin
      if (buf_full_q) begin
        shadow_l_d = left_q;
        shadow_r_d = right_q;
        buf_full_d = 1'b0;
      end else begin
        shadow_l_d = '0;
        shadow_r_d = '0;
        underrun_d = 1'b1;
      end
    end

    // Acceptance only happens while the buffer is empty, so it never
    // collides with a frame-start load of a full buffer.
    if (store_left) left_d = s_axis.s_axis_data[23:0];
    if (store_right) begin
      right_d    = s_axis.s_axis_data[23:0];
      buf_full_d = 1'b1;
    end

    ready_d = !buf_full_d;
  end

  // ---------------------------------------------------------------------------
  // Bit clock, bit counter and serializer
  // ---------------------------------------------------------------------------
  always_comb begin
    clk_cnt_d   = clk_cnt_q + CW'(1);
    sclk_d      = sclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrck_d      = lrck_q;
    sdout_d     = sdout_q;
    slot_pos    = 5'd0;
    sample_idx  = 5'd0;
    slot_sample = '0;

    if (half_tick) begin
      clk_cnt_d = '0;
      sclk_d    = !sclk_q;
    end

    if (fall_tick) begin
      bit_cnt_d   = bit_cnt_q + 6'd1;
      slot_pos    = bit_cnt_d[4:0];
      lrck_d      = bit_cnt_d[5];
      // Position 0 is always 0, so the shadow load on the same edge is never
      // needed before position 1.
      slot_sample = bit_cnt_d[5] ? shadow_r_q : shadow_l_q;
      sdout_d     = 1'b0;
      if (slot_pos >= 5'd1 && slot_pos <= 5'd24) begin
        sample_idx = 5'd24 - slot_pos;
        sdout_d    = slot_sample[sample_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the packet buffer and shadow registers are reset too, because a
    // reset must discard any buffered or partially received packet.
    if (reset) begin
      clk_cnt_q     <= '0;
      sclk_q        <= 1'b0;
      bit_cnt_q     <= '0;
      lrck_q        <= 1'b0;
      sdout_q       <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      buf_full_q    <= 1'b0;
      shadow_l_q    <= '0;
      shadow_r_q    <= '0;
      ready_q       <= 1'b1;
      underrun_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      clk_cnt_q     <= clk_cnt_d;
      sclk_q        <= sclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      sdout_q       <= sdout_d;
      left_q        <= left_d;
      right_q       <= right_d;
      buf_full_q    <= buf_full_d;
      shadow_l_q    <= shadow_l_d;
      shadow_r_q    <= shadow_r_d;
      ready_q       <= ready_d;
      underrun_q    <= underrun_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign s_axis.s_axis_ready = ready_q;
  assign i2s_sclk            = sclk_q;
  assign i2s_lrck            = lrck_q;
  assign i2s_sdout           = sdout_q;
  assign underrun            = underrun_q;
  assign framing_err         = framing_err_q;

endmodule
